// File: rtl/hall_pulse_conditioner.sv
// Hall-sensor front end: per-channel synchroniser, debounce filter, rise strobe,
// rise-to-rise period measurement with stall detection, and a selectable period readout.
module hall_pulse_conditioner #(
  parameter int N_CHANNELS      = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_CHANNELS-1:0]   hall_in,
  output logic [N_CHANNELS-1:0]   pulse_level,
  output logic [N_CHANNELS-1:0]   pulse_rise,
  output logic [N_CHANNELS-1:0]   stall,
  output logic [N_CHANNELS-1:0]   period_valid,
  input  logic [3:0]              period_sel,
  output logic [PERIOD_WIDTH-1:0] period_data
);

  localparam logic [7:0]              CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] PC_MAX   = '1;
  localparam logic [PERIOD_WIDTH-1:0] PC_ONE   = PERIOD_WIDTH'(1);

  logic [N_CHANNELS-1:0]   sync1_q, sync2_q;
  logic [N_CHANNELS-1:0]   filt_q, filt_d;
  logic [N_CHANNELS-1:0]   rise_q, rise_d;
  logic [N_CHANNELS-1:0]   stall_q, stall_d;
  logic [N_CHANNELS-1:0]   rise_seen_q, rise_seen_d;
  logic [N_CHANNELS-1:0]   pvalid_q, pvalid_d;
  logic [7:0]              cnt_q  [N_CHANNELS];
  logic [7:0]              cnt_d  [N_CHANNELS];
  logic [PERIOD_WIDTH-1:0] pc_q   [N_CHANNELS];
  logic [PERIOD_WIDTH-1:0] pc_d   [N_CHANNELS];
  logic [PERIOD_WIDTH-1:0] preg_q [N_CHANNELS];
  logic [PERIOD_WIDTH-1:0] preg_d [N_CHANNELS];
  logic [PERIOD_WIDTH-1:0] pdata_q, pdata_d;
  logic [N_CHANNELS-1:0]   accept;
  logic [N_CHANNELS-1:0]   rise_acc;

  always_comb begin
    accept   = '0;
    rise_acc = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      accept[i]   = enable && (sync2_q[i] != filt_q[i]) && (cnt_q[i] == CNT_LAST);
      rise_acc[i] = accept[i] && sync2_q[i];
    end
  end

  always_comb begin
    filt_d      = filt_q;
    rise_d      = '0;
    stall_d     = stall_q;
    rise_seen_d = rise_seen_q;
    pvalid_d    = pvalid_q;
    for (int i = 0; i < N_CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      pc_d[i]   = pc_q[i];
      preg_d[i] = preg_q[i];
      if (!enable) begin
        filt_d[i]      = 1'b0;
        stall_d[i]     = 1'b0;
        rise_seen_d[i] = 1'b0;
        pvalid_d[i]    = 1'b0;
        cnt_d[i]       = '0;
        pc_d[i]        = '0;
        preg_d[i]      = '0;
      end else begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (!accept[i]) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end else begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end
        // A rise on the saturating edge wins: the counter restarts and stall clears.
        if (rise_acc[i]) begin
          preg_d[i]      = pc_q[i];
          pc_d[i]        = PC_ONE;
          stall_d[i]     = 1'b0;
          rise_seen_d[i] = 1'b1;
          pvalid_d[i]    = pvalid_q[i] | rise_seen_q[i];
          rise_d[i]      = 1'b1;
        end else begin
          pc_d[i]    = (pc_q[i] == PC_MAX) ? pc_q[i] : pc_q[i] + PC_ONE;
          stall_d[i] = stall_q[i] | (pc_q[i] == PC_MAX);
        end
      end
    end
  end

  always_comb begin
    pdata_d = '0;
    if (enable) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (period_sel == 4'(i)) pdata_d = preg_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      rise_q      <= '0;
      stall_q     <= '0;
      rise_seen_q <= '0;
      pvalid_q    <= '0;
      pdata_q     <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        pc_q[i]   <= '0;
        preg_q[i] <= '0;
      end
    end else begin
      sync1_q     <= hall_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      rise_q      <= rise_d;
      stall_q     <= stall_d;
      rise_seen_q <= rise_seen_d;
      pvalid_q    <= pvalid_d;
      pdata_q     <= pdata_d;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pc_q[i]   <= pc_d[i];
        preg_q[i] <= preg_d[i];
      end
    end
  end

  assign pulse_level  = filt_q;
  assign pulse_rise   = rise_q;
  assign stall        = stall_q;
  assign period_valid = pvalid_q;
  assign period_data  = pdata_q;

endmodule
